// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch (IF)
// port and the data (MA) port. A single transaction is outstanding at a time:
// grant in IDLE, issue the request, then collect the read response.
// Optional feature: define ARB_RR_EN for a round-robin tie-break between IF and
// MA. With it undefined, MA always wins a tie.
//
// Handshake rules: a memory request transfers in the cycle mem_req and
// mem_req_ready are both 1; mem_req and its fields stay stable until then. A
// read response transfers in the cycle mem_rdata_valid and mem_rdata_ready are
// both 1; mem_rdata_valid seen while mem_rdata_ready is 0 is ignored.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        if_flush,
    // data port
    input  logic        ma_req,
    input  logic        ma_wen,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    input  logic [3:0]  ma_wstrb,
    output logic        ma_gnt,
    output logic [31:0] ma_rdata,
    output logic        ma_done,
    // memory bus
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_req_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic        mem_rdata_ready,
    // debug: current FSM state
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_REQ  = 3'd1,
        I_RESP = 3'd2,
        D_REQ  = 3'd3,
        D_RESP = 3'd4
    } state_t;

    state_t state, state_next;
    logic   drop_q, drop_next;
    logic   if_eff;
    logic   ma_win, if_win;
    logic   wen_q;

`ifdef ARB_RR_EN
    // 1 when MA received the most recent grant; resets to "IF last"
    logic   last_ma_q;

    // Remember who was granted last so a tie goes to the other requester
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ma_q <= 1'b0;
        end else if (ma_win) begin
            last_ma_q <= 1'b1;
        end else if (if_win) begin
            last_ma_q <= 1'b0;
        end
    end
`endif

    // Arbitration, only in IDLE; a flush in the same cycle cancels the fetch request
    always_comb begin
        if_eff = if_req && !if_flush;
        ma_win = 1'b0;
        if_win = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef ARB_RR_EN
            if (ma_req && if_eff) begin
                ma_win = !last_ma_q;
                if_win = last_ma_q;
            end else begin
                ma_win = ma_req;
                if_win = if_eff;
            end
`else
            ma_win = ma_req;
            if_win = if_eff && !ma_req;
`endif
        end
    end

    // State and drop-flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else begin
            state  <= state_next;
            drop_q <= drop_next;
        end
    end

    // Next-state logic; the drop flag lives only while a fetch is in flight
    always_comb begin
        state_next = state;
        drop_next  = drop_q;
        case (state)
            IDLE: begin
                drop_next = 1'b0;
                if (ma_win) begin
                    state_next = D_REQ;
                end else if (if_win) begin
                    state_next = I_REQ;
                end
            end
            I_REQ: begin
                if (if_flush) begin
                    drop_next = 1'b1;
                end
                if (mem_req_ready) begin
                    state_next = I_RESP;
                end
            end
            I_RESP: begin
                if (if_flush) begin
                    drop_next = 1'b1;
                end
                if (mem_rdata_valid) begin
                    state_next = IDLE;
                    drop_next  = 1'b0;
                end
            end
            D_REQ: begin
                if (mem_req_ready) begin
                    state_next = wen_q ? IDLE : D_RESP;
                end
            end
            D_RESP: begin
                if (mem_rdata_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                drop_next  = 1'b0;
            end
        endcase
    end

    // Latch the winning request's fields; they drive the bus until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q     <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else if (ma_win) begin
            wen_q     <= ma_wen;
            mem_addr  <= ma_addr;
            mem_wdata <= ma_wdata;
            mem_wstrb <= ma_wstrb;
        end else if (if_win) begin
            wen_q     <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end
    end

    // Register responses and completion pulses; a dropped fetch is consumed silently
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata  <= 32'h0;
            if_rvalid <= 1'b0;
            ma_rdata  <= 32'h0;
            ma_done   <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ma_done   <= 1'b0;
            if (state == I_RESP && mem_rdata_valid && !(drop_q || if_flush)) begin
                if_rdata  <= mem_rdata;
                if_rvalid <= 1'b1;
            end
            if (state == D_RESP && mem_rdata_valid) begin
                ma_rdata <= mem_rdata;
                ma_done  <= 1'b1;
            end
            if (state == D_REQ && mem_req_ready && wen_q) begin
                ma_done <= 1'b1;
            end
        end
    end

    // Decoded bus outputs; reset forces the handshake outputs low at once
    always_comb begin
        if_gnt          = if_win;
        ma_gnt          = ma_win;
        mem_req         = !rst && (state == I_REQ || state == D_REQ);
        mem_rdata_ready = !rst && (state == I_RESP || state == D_RESP);
        mem_wen         = wen_q;
        state_dbg       = state;
    end

endmodule
